// File: rtl/match_sequencer.sv
// Match flow controller for a two-player ball game: start, serve delay, play, scoring, game over.
// Optional pause support is compiled in when MATCH_PAUSE_EN is defined.
module match_sequencer #(
   parameter int POINTS_TO_WIN         = 7,
   parameter int SERVE_DELAY_IN_CLOCKS = 25000000,
   localparam int SW                   = $clog2(POINTS_TO_WIN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_button,
   input  logic          goal_1,
   input  logic          goal_2,
   input  logic          pause_button,
   output logic          game_rst_n,
   output logic          move_enable,
   output logic [SW-1:0] score_1,
   output logic [SW-1:0] score_2,
   output logic [1:0]    winner,
   output logic [2:0]    state_out
);

   localparam int CW = $clog2(SERVE_DELAY_IN_CLOCKS);
   localparam logic [SW-1:0] WIN_SCORE = SW'(POINTS_TO_WIN);
   localparam logic [CW-1:0] LAST_CNT  = CW'(SERVE_DELAY_IN_CLOCKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_POINT     = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_PAUSED    = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] score_1_q, score_1_d;
   logic [SW-1:0] score_2_q, score_2_d;
   logic [1:0]    winner_q, winner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_prev_q;
   logic          start_evt;

   assign start_evt = start_button & ~start_prev_q;

`ifdef MATCH_PAUSE_EN
   logic pause_prev_q;
   logic pause_evt;
   assign pause_evt = pause_button & ~pause_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pause_prev_q <= 1'b0;
      else     pause_prev_q <= pause_button;
   end
`else
   logic unused_pause;
   assign unused_pause = pause_button;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         score_1_q    <= '0;
         score_2_q    <= '0;
         winner_q     <= 2'b00;
         cnt_q        <= '0;
         start_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_1_q    <= score_1_d;
         score_2_q    <= score_2_d;
         winner_q     <= winner_d;
         cnt_q        <= cnt_d;
         start_prev_q <= start_button;
      end
   end

   always_comb begin
      state_d   = state_q;
      score_1_d = score_1_q;
      score_2_d = score_2_q;
      winner_d  = winner_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_evt) begin
               state_d   = ST_SERVE;
               score_1_d = '0;
               score_2_d = '0;
               winner_d  = 2'b00;
               cnt_d     = '0;
            end
         end
         ST_SERVE: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = ST_PLAY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PLAY: begin
            // A simultaneous goal pair is a no-score rally end.
            if (goal_1 || goal_2) begin
               state_d = ST_POINT;
               if (goal_1 && !goal_2)
                  score_1_d = (score_1_q == WIN_SCORE) ? WIN_SCORE : score_1_q + 1'b1;
               else if (goal_2 && !goal_1)
                  score_2_d = (score_2_q == WIN_SCORE) ? WIN_SCORE : score_2_q + 1'b1;
            end
`ifdef MATCH_PAUSE_EN
            else if (pause_evt) begin
               state_d = ST_PAUSED;
            end
`endif
         end
         ST_POINT: begin
            if (score_1_q == WIN_SCORE) begin
               state_d  = ST_GAME_OVER;
               winner_d = 2'b01;
            end else if (score_2_q == WIN_SCORE) begin
               state_d  = ST_GAME_OVER;
               winner_d = 2'b10;
            end else begin
               state_d = ST_SERVE;
               cnt_d   = '0;
            end
         end
`ifdef MATCH_PAUSE_EN
         ST_PAUSED: begin
            if (pause_evt) state_d = ST_PLAY;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign game_rst_n  = (state_q == ST_PLAY) || (state_q == ST_POINT) || (state_q == ST_PAUSED);
   assign move_enable = (state_q == ST_PLAY);
   assign score_1     = score_1_q;
   assign score_2     = score_2_q;
   assign winner      = winner_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer (POINTS_TO_WIN=3, SERVE_DELAY_IN_CLOCKS=4).
module tb_match_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                          S_POINT = 3'd3, S_OVER = 3'd4, S_PAUSED = 3'd5;

   logic       clk, rst;
   logic       start_button, goal_1, goal_2, pause_button;
   logic       game_rst_n, move_enable;
   logic [1:0] score_1, score_2, winner;
   logic [2:0] state_out;

   typedef struct {
      logic [2:0] st;
      logic [1:0] s1;
      logic [1:0] s2;
      logic [1:0] w;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   match_sequencer #(.POINTS_TO_WIN(3), .SERVE_DELAY_IN_CLOCKS(4)) dut (
      .clk(clk), .rst(rst), .start_button(start_button), .goal_1(goal_1),
      .goal_2(goal_2), .pause_button(pause_button), .game_rst_n(game_rst_n),
      .move_enable(move_enable), .score_1(score_1), .score_2(score_2),
      .winner(winner), .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void compare(input exp_t e);
      logic grn, me;
      grn = (e.st == S_PLAY) || (e.st == S_POINT) || (e.st == S_PAUSED);
      me  = (e.st == S_PLAY);
      checks++;
      if (state_out !== e.st || score_1 !== e.s1 || score_2 !== e.s2 || winner !== e.w ||
          game_rst_n !== grn || move_enable !== me) begin
         errors++;
         $display("FAIL %s: got state=%0d s1=%0d s2=%0d win=%b grn=%b me=%b, expected state=%0d s1=%0d s2=%0d win=%b grn=%b me=%b",
                  e.nm, state_out, score_1, score_2, winner, game_rst_n, move_enable,
                  e.st, e.s1, e.s2, e.w, grn, me);
      end else begin
         $display("txn %-16s state=%0d s1=%0d s2=%0d win=%b grn=%b me=%b ok",
                  e.nm, state_out, score_1, score_2, winner, game_rst_n, move_enable);
      end
   endfunction

   // Monitor: every expectation queued this cycle is checked at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) compare(exp_q.pop_front());
   end

   // Queue the expected registered state for this cycle, then drive inputs for the next edge.
   task automatic cyc(input logic st, input logic g1, input logic g2, input logic pb,
                      input logic [2:0] es, input logic [1:0] e1, input logic [1:0] e2,
                      input logic [1:0] ew, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      start_button = st;
      goal_1       = g1;
      goal_2       = g2;
      pause_button = pb;
      e.st = es; e.s1 = e1; e.s2 = e2; e.w = ew; e.nm = nm;
      exp_q.push_back(e);
   endtask

   task automatic serve4(input logic [1:0] e1, input logic [1:0] e2);
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 0, 0, S_SERVE, e1, e2, 2'b00, $sformatf("serve_%0d", i));
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      start_button = 0; goal_1 = 0; goal_2 = 0; pause_button = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      cyc(1, 0, 0, 0, S_IDLE,  0, 0, 0, "idle_start");
      cyc(0, 0, 0, 0, S_SERVE, 0, 0, 0, "serve_0");
      cyc(0, 0, 1, 0, S_SERVE, 0, 0, 0, "serve_1_goal2");
      cyc(0, 0, 0, 0, S_SERVE, 0, 0, 0, "serve_2");
      cyc(0, 0, 0, 0, S_SERVE, 0, 0, 0, "serve_3");
      cyc(1, 0, 0, 0, S_PLAY,  0, 0, 0, "play_start_ign");
      cyc(0, 1, 0, 0, S_PLAY,  0, 0, 0, "play_goal1");
      cyc(0, 0, 0, 0, S_POINT, 1, 0, 0, "point_1");
      serve4(1, 0);
      cyc(0, 1, 1, 0, S_PLAY,  1, 0, 0, "play_both");
      cyc(0, 0, 0, 0, S_POINT, 1, 0, 0, "point_both");
      serve4(1, 0);
      cyc(0, 0, 0, 1, S_PLAY,  1, 0, 0, "play_pause");
`ifdef MATCH_PAUSE_EN
      cyc(0, 1, 0, 0, S_PAUSED, 1, 0, 0, "paused_goal1");
      cyc(0, 0, 0, 0, S_PAUSED, 1, 0, 0, "paused_hold");
      cyc(0, 0, 0, 1, S_PAUSED, 1, 0, 0, "paused_resume");
`endif
      cyc(0, 1, 0, 0, S_PLAY,  1, 0, 0, "play_goal1_b");
      cyc(0, 0, 0, 0, S_POINT, 2, 0, 0, "point_2");
      serve4(2, 0);
      cyc(0, 1, 0, 0, S_PLAY,  2, 0, 0, "play_goal1_c");
      cyc(0, 0, 0, 0, S_POINT, 3, 0, 0, "point_3");
      cyc(0, 0, 1, 0, S_OVER,  3, 0, 1, "over_goal2_ign");
      cyc(1, 0, 0, 0, S_OVER,  3, 0, 1, "over_start");
      serve4(0, 0);
      cyc(0, 0, 1, 0, S_PLAY,  0, 0, 0, "play_goal2");
      cyc(0, 0, 0, 0, S_POINT, 0, 1, 0, "point_s2");
      serve4(0, 1);
      cyc(0, 1, 0, 0, S_PLAY,  0, 1, 0, "play_g1_a");
      cyc(0, 0, 0, 0, S_POINT, 1, 1, 0, "point_11");
      serve4(1, 1);
      cyc(0, 1, 0, 0, S_PLAY,  1, 1, 0, "play_g1_b");
      cyc(0, 0, 0, 0, S_POINT, 2, 1, 0, "point_21");
      serve4(2, 1);
      cyc(0, 0, 0, 0, S_PLAY,  2, 1, 0, "play_pre_rst");

      // Mid-cycle reset with no clock edge: outputs must clear immediately.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      e.st = S_IDLE; e.s1 = 0; e.s2 = 0; e.w = 0; e.nm = "async_rst";
      compare(e);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(0, 1, 0, 0, S_IDLE, 0, 0, 0, "post_rst_goal");
      cyc(0, 0, 0, 0, S_IDLE, 0, 0, 0, "post_rst_idle");
      @(negedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL have parameter POINTS_TO_WIN, default 7: score that ends a match; legal range 1..15.
REQ-002 SHALL have parameter SERVE_DELAY_IN_CLOCKS, default 25000000: cycles spent in SERVE before play resumes; legal range >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start_button  input  1  synchronous, already debounced level.
REQ-006 SHALL have port goal_1  input  1  one-cycle pulse: player 1 scored.
REQ-007 SHALL have port goal_2  input  1  one-cycle pulse: player 2 scored.
REQ-008 SHALL have port pause_button  input  1  debounced level; used only when MATCH_PAUSE_EN is defined.
REQ-009 SHALL have port game_rst_n  output  1  active-low hold for the game datapath; 0 re-centres ball and paddles.
REQ-010 SHALL have port move_enable  output  1  1 = datapath may advance ball and paddles.
REQ-011 SHALL have port score_1  output  SW  player 1 score; SW = $clog2(POINTS_TO_WIN+1).
REQ-012 SHALL have port score_2  output  SW  player 2 score.
REQ-013 SHALL have port winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-014 SHALL have port state_out  output  3  current state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4, PAUSED=5.

Function
REQ-015 SHALL detect a start event as a rising edge of start_button: registered previous value 0, current value 1.
REQ-016 SHALL go from IDLE to SERVE on a start event, clearing both scores and winner in the same cycle.
REQ-017 SHALL, in SERVE, count SERVE_DELAY_IN_CLOCKS cycles starting at 0, then enter PLAY on the cycle after the count reaches SERVE_DELAY_IN_CLOCKS-1.
REQ-018 SHALL drive game_rst_n=0 in IDLE, SERVE and GAME_OVER, and game_rst_n=1 in PLAY, POINT and PAUSED.
REQ-019 SHALL drive move_enable=1 only in PLAY, combinationally decoded from the registered state.
REQ-020 SHALL honour goal_1 and goal_2 only in PLAY; pulses in any other state are ignored.
REQ-021 SHALL, on goal_1 alone in PLAY, increment score_1 and enter POINT on the next edge; goal_2 alone likewise increments score_2.
REQ-022 SHALL, when goal_1 and goal_2 arrive in the same PLAY cycle, leave both scores unchanged and enter POINT.
REQ-023 SHALL stay in POINT for exactly one cycle; it then enters GAME_OVER if either score equals POINTS_TO_WIN, otherwise SERVE with the delay counter cleared.
REQ-024 SHALL, on entering GAME_OVER, set winner to the player whose score equals POINTS_TO_WIN.
REQ-025 SHALL hold scores and winner in GAME_OVER; a start event there clears both and enters SERVE.
REQ-026 SHALL saturate scores at POINTS_TO_WIN; scores SHALL never wrap around.
REQ-027 SHALL ignore start events in SERVE, PLAY, POINT and PAUSED.
REQ-028 SHALL force any illegal state encoding to IDLE on the next edge.

Reset
REQ-029 SHALL, while rst=1, immediately force state IDLE, scores 0, winner 00, delay counter 0 and edge registers 0, giving game_rst_n=0 and move_enable=0.
REQ-030 SHALL, when rst asserts mid-SERVE or mid-PLAY, abandon the match with no pending score update; after release a fresh start event is required.

Configuration
REQ-031 SHALL compile pause support only when macro MATCH_PAUSE_EN is defined.
REQ-032 SHALL, with MATCH_PAUSE_EN defined: a pause_button rising edge in PLAY enters PAUSED with move_enable=0; another rising edge in PAUSED returns to PLAY; goals in PAUSED are ignored.
REQ-033 SHALL, without MATCH_PAUSE_EN: ignore pause_button, never enter PAUSED, and synthesize no pause edge register.

Verification (POINTS_TO_WIN=3, SERVE_DELAY_IN_CLOCKS=4)
REQ-034 SHALL cover: reset release, then start pulse -> SERVE for 4 cycles with game_rst_n=0, then PLAY with move_enable=1.
REQ-035 SHALL cover: three goal_1 pulses, each in PLAY -> score_1 steps 1,2,3; GAME_OVER with winner=01; score_2=0.
REQ-036 SHALL cover: goal_1 and goal_2 in the same cycle -> scores unchanged; POINT for 1 cycle, then SERVE.
REQ-037 SHALL cover: goal_2 pulse during SERVE, then start pulse during PLAY -> both ignored; scores and state unchanged.
REQ-038 SHALL cover: rst asserted in PLAY with score_1=2 -> outputs reset asynchronously without waiting for a clock edge; state IDLE, scores 0.
REQ-039 SHALL cover, with MATCH_PAUSE_EN defined: pause edge in PLAY, then goal_1 pulse, then pause edge -> PAUSED, score_1 unchanged, back to PLAY.
